// File: rtl/clock_pkg.sv
// Shared encodings and digit limits for the HH:MM:SS clock sequencer.
package clock_pkg;

  localparam logic [3:0] ST_RESET = 4'd0;
  localparam logic [3:0] ST_SET   = 4'd1;
  localparam logic [3:0] ST_START = 4'd3;

  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t DIG_SU = 3'd0;
  localparam digit_idx_t DIG_ST = 3'd1;
  localparam digit_idx_t DIG_MU = 3'd2;
  localparam digit_idx_t DIG_MT = 3'd3;
  localparam digit_idx_t DIG_HU = 3'd4;
  localparam digit_idx_t DIG_HT = 3'd5;

  localparam logic [3:0] SU_MAX = 4'd9;
  localparam logic [3:0] ST_MAX = 4'd5;
  localparam logic [3:0] MU_MAX = 4'd9;
  localparam logic [3:0] MT_MAX = 4'd5;
  localparam logic [3:0] HU_MAX = 4'd9;
  localparam logic [3:0] HT_MAX = 4'd2;
  localparam logic [3:0] HOUR_UNITS_MAX_AT_20 = 4'd3;

  // Largest legal value of a digit; hour units depends on the hour tens digit.
  function automatic logic [3:0] digit_max(input digit_idx_t idx, input logic [3:0] ht);
    logic [3:0] m;
    case (idx)
      DIG_SU:  m = SU_MAX;
      DIG_ST:  m = ST_MAX;
      DIG_MU:  m = MU_MAX;
      DIG_MT:  m = MT_MAX;
      DIG_HU:  m = (ht == HT_MAX) ? HOUR_UNITS_MAX_AT_20 : HU_MAX;
      DIG_HT:  m = HT_MAX;
      default: m = 4'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second tick counter: wraps at TICK_MAX, clears or holds under control of the sequencer.
module tick_gen #(
  parameter int unsigned TICK_MAX = 49_999_999,
  parameter int unsigned CNT_W    = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             run,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(TICK_MAX);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == MaxCnt) ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tick  = run && (count_q == MaxCnt);

endmodule

// File: rtl/clock_controller.sv
// Run-state FSM, carry chain and SET-mode digit editor for the six-digit 24-hour clock.
module clock_controller
  import clock_pkg::*;
#(
  parameter int unsigned TICK_MAX = 49_999_999,
  parameter int unsigned CNT_W    = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_reset,
  input  logic             btn_set,
  input  logic             btn_start,
  input  logic             btn_next,
  input  logic             btn_inc,
  input  logic [23:0]      current_bits,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] r_count,
  output logic             tick,
  output logic [5:0]       carry,
  output logic [2:0]       set_sel,
  output logic [23:0]      set_bits
);

  logic [3:0]  state_q, state_d;
  logic        run_q;
  logic [2:0]  set_sel_q, set_sel_d;
  logic [23:0] set_bits_q, set_bits_d;
  logic [3:0]  sel_val, sel_max, new_val;

  always_comb begin
    state_d = state_q;
    if (btn_reset) begin
      state_d = ST_RESET;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (btn_start)    state_d = ST_START;
          else if (btn_set) state_d = ST_SET;
        end
        ST_SET:   if (btn_start) state_d = ST_START;
        ST_START: state_d = ST_START;
        default:  state_d = ST_RESET;
      endcase
    end
  end

  // Counting starts one cycle after entry so the first tick lands TICK_MAX+1 cycles later.
  tick_gen #(
    .TICK_MAX (TICK_MAX),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run_q),
    .clr   ((state_q != ST_START) || (state_d != ST_START)),
    .run   (state_q == ST_START),
    .count (r_count),
    .tick  (tick)
  );

  always_comb begin
    carry = '0;
    if (state_q == ST_START) begin
      carry[0] = 1'b1;
      carry[1] = current_bits[3:0] == 4'd9;
      carry[2] = carry[1] && (current_bits[7:4] == 4'd5);
      carry[3] = carry[2] && (current_bits[11:8] == 4'd9);
      carry[4] = carry[3] && (current_bits[15:12] == 4'd5);
      carry[5] = carry[4] && ((current_bits[19:16] == 4'd9) ||
                              ((current_bits[23:20] == 4'd2) && (current_bits[19:16] == 4'd3)));
    end
  end

  always_comb begin
    set_sel_d  = set_sel_q;
    set_bits_d = set_bits_q;
    sel_val    = set_bits_q[{set_sel_q, 2'b00} +: 4];
    sel_max    = digit_max(set_sel_q, set_bits_q[23:20]);
    new_val    = (sel_val >= sel_max) ? 4'd0 : sel_val + 4'd1;
    if (state_d == ST_RESET) begin
      set_bits_d = '0;
      set_sel_d  = '0;
    end else if (state_d != ST_SET || state_q != ST_SET) begin
      // Leaving or entering SET: edits are dropped and the cursor returns to seconds.
      set_sel_d = '0;
    end else begin
      if (btn_inc && set_sel_q <= DIG_HT) begin
        set_bits_d[{set_sel_q, 2'b00} +: 4] = new_val;
        if (set_sel_q == DIG_HT && new_val == HT_MAX &&
            set_bits_q[19:16] > HOUR_UNITS_MAX_AT_20) begin
          set_bits_d[19:16] = HOUR_UNITS_MAX_AT_20;
        end
      end
      if (btn_next) begin
        set_sel_d = (set_sel_q >= DIG_HT) ? DIG_SU : set_sel_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RESET;
      run_q      <= 1'b0;
      set_sel_q  <= '0;
      set_bits_q <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= (state_q == ST_START);
      set_sel_q  <= set_sel_d;
      set_bits_q <= set_bits_d;
    end
  end

  assign state    = state_q;
  assign set_sel  = set_sel_q;
  assign set_bits = set_bits_q;

endmodule

// File: tb/tb_clock_controller.sv
// Bench for clock_controller: vector table through a scoreboard queue, then tick and reset sequences.
module tb_clock_controller;

  localparam int unsigned CNT_W = 26;
  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_RST  = 5'b10000;
  localparam logic [4:0] B_SET  = 5'b01000;
  localparam logic [4:0] B_STA  = 5'b00100;
  localparam logic [4:0] B_NXT  = 5'b00010;
  localparam logic [4:0] B_INC  = 5'b00001;
  localparam logic [23:0] T235959 = 24'h235959;
  localparam logic [23:0] T123459 = 24'h123459;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             btn_reset = 1'b0, btn_set = 1'b0, btn_start = 1'b0;
  logic             btn_next = 1'b0, btn_inc = 1'b0;
  logic [23:0]      current_bits = '0;
  logic [3:0]       state;
  logic [CNT_W-1:0] r_count;
  logic             tick;
  logic [5:0]       carry;
  logic [2:0]       set_sel;
  logic [23:0]      set_bits;

  clock_controller #(
    .TICK_MAX (9),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_reset    (btn_reset),
    .btn_set      (btn_set),
    .btn_start    (btn_start),
    .btn_next     (btn_next),
    .btn_inc      (btn_inc),
    .current_bits (current_bits),
    .state        (state),
    .r_count      (r_count),
    .tick         (tick),
    .carry        (carry),
    .set_sel      (set_sel),
    .set_bits     (set_bits)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  btn;
    logic [23:0] cur;
    logic [3:0]  st;
    bit          chk_sel;
    logic [2:0]  sel;
    logic [23:0] bits;
    logic [5:0]  car;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   tq[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic void add(string nm, logic [4:0] b, logic [23:0] cur, logic [3:0] st,
                              bit cs, logic [2:0] sel, logic [23:0] bits, logic [5:0] car);
    vecs.push_back('{nm, b, cur, st, cs, sel, bits, car});
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
  endtask

  // Drive one cycle of button pulses; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic [4:0] b, input logic [23:0] cur);
    {btn_reset, btn_set, btn_start, btn_next, btn_inc} = b;
    current_bits = cur;
    @(posedge clk);
    #1;
    {btn_reset, btn_set, btn_start, btn_next, btn_inc} = B_NONE;
  endtask

  initial begin
    vec_t e;
    int   cnt;

    // Table: state, set_sel (where defined), set_bits and carry after each cycle.
    add("idle",        B_NONE,        T235959, 0, 1, 0, 24'h000000, 6'h00);
    add("enter_set",   B_SET,         T235959, 1, 1, 0, 24'h000000, 6'h00);
    for (int k = 1; k <= 5; k++)
      add("next_to_ht", B_NXT,        T235959, 1, 1, 3'(k), 24'h000000, 6'h00);
    add("ht_inc1",     B_INC,         T235959, 1, 1, 5, 24'h100000, 6'h00);
    add("ht_inc2",     B_INC,         T235959, 1, 1, 5, 24'h200000, 6'h00);
    add("ht_wrap",     B_INC,         T235959, 1, 1, 5, 24'h000000, 6'h00);
    add("sel_wrap",    B_NXT,         T235959, 1, 1, 0, 24'h000000, 6'h00);
    for (int k = 1; k <= 4; k++)
      add("next_to_hu", B_NXT,        T235959, 1, 1, 3'(k), 24'h000000, 6'h00);
    for (int k = 1; k <= 7; k++)
      add("hu_inc",    B_INC,         T235959, 1, 1, 4, 24'(k) << 16, 6'h00);
    add("next_ht",     B_NXT,         T235959, 1, 1, 5, 24'h070000, 6'h00);
    add("ht_to1",      B_INC,         T235959, 1, 1, 5, 24'h170000, 6'h00);
    add("ht2_clamp",   B_INC,         T235959, 1, 1, 5, 24'h230000, 6'h00);
    add("sel_wrap2",   B_NXT,         T235959, 1, 1, 0, 24'h230000, 6'h00);
    for (int k = 1; k <= 4; k++)
      add("su_inc",    B_INC,         T235959, 1, 1, 0, 24'h230000 | 24'(k), 6'h00);
    add("inc_next",    B_INC | B_NXT, T235959, 1, 1, 1, 24'h230005, 6'h00);
    for (int k = 2; k <= 4; k++)
      add("next_to_hu2", B_NXT,       T235959, 1, 1, 3'(k), 24'h230005, 6'h00);
    add("hu_wrap_20",  B_INC,         T235959, 1, 1, 4, 24'h200005, 6'h00);
    add("set_in_set",  B_SET,         T235959, 1, 1, 4, 24'h200005, 6'h00);
    add("start",       B_STA,         T235959, 3, 0, 0, 24'h200005, 6'h3f);
    add("carry_1234",  B_NONE,        T123459, 3, 0, 0, 24'h200005, 6'h07);
    add("set_in_start", B_SET,        T123459, 3, 0, 0, 24'h200005, 6'h07);
    add("edit_in_start", B_INC | B_NXT, 24'h0, 3, 0, 0, 24'h200005, 6'h01);
    add("reset_prio",  B_RST | B_SET, T235959, 0, 0, 0, 24'h000000, 6'h00);
    add("set_inc_drop", B_SET | B_INC, T235959, 1, 1, 0, 24'h000000, 6'h00);
    add("su_inc_again", B_INC,        T235959, 1, 1, 0, 24'h000001, 6'h00);
    add("reset_clear", B_RST,         T235959, 0, 0, 0, 24'h000000, 6'h00);
    add("start_prio",  B_STA | B_SET, T235959, 3, 0, 0, 24'h000000, 6'h3f);
    add("reset_again", B_RST,         T235959, 0, 0, 0, 24'h000000, 6'h00);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.r_count", 32'(r_count), 32'd0);
    chk("rst.tick", 32'(tick), 32'd0);
    chk("rst.carry", 32'(carry), 32'd0);
    chk("rst.set_sel", 32'(set_sel), 32'd0);
    chk("rst.set_bits", 32'(set_bits), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      sb.push_back(vecs[i]);
      drive(vecs[i].btn, vecs[i].cur);
      e = sb.pop_front();
      chk($sformatf("%s[%0d].state", e.name, i), 32'(state), 32'(e.st));
      if (e.chk_sel) chk($sformatf("%s[%0d].set_sel", e.name, i), 32'(set_sel), 32'(e.sel));
      chk($sformatf("%s[%0d].set_bits", e.name, i), 32'(set_bits), 32'(e.bits));
      chk($sformatf("%s[%0d].carry", e.name, i), 32'(carry), 32'(e.car));
    end

    // Tick timing: first tick 10 cycles after state reads 3, then every 10 cycles.
    drive(B_STA, T235959);
    chk("tick.entry_state", 32'(state), 32'd3);
    chk("tick.entry_count", 32'(r_count), 32'd0);
    chk("tick.entry_tick", 32'(tick), 32'd0);
    repeat (3) tq.push_back(10);
    cnt = 0;
    for (int c = 0; c < 100 && tq.size() > 0; c++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (tick) begin
        chk("tick.gap", 32'(cnt), 32'(tq.pop_front()));
        cnt = 0;
      end
    end
    chk("tick.pending", 32'(tq.size()), 32'd0);
    chk("tick.count_at_tick", 32'(r_count), 32'd9);
    chk("tick.carry_at_tick", 32'(carry), 32'h3f);
    drive(B_RST, T235959);
    chk("tick.rst_state", 32'(state), 32'd0);
    chk("tick.rst_count", 32'(r_count), 32'd0);
    chk("tick.rst_tick", 32'(tick), 32'd0);
    chk("tick.rst_carry", 32'(carry), 32'd0);

    // Asynchronous reset in the middle of a count, with edits held from SET.
    drive(B_SET, T235959);
    drive(B_INC, T235959);
    drive(B_STA, T235959);
    chk("async.held_bits", 32'(set_bits), 32'h000001);
    for (int c = 0; c < 20 && r_count != 5; c++) begin
      @(posedge clk);
      #1;
    end
    chk("async.count5", 32'(r_count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async.state", 32'(state), 32'd0);
    chk("async.r_count", 32'(r_count), 32'd0);
    chk("async.tick", 32'(tick), 32'd0);
    chk("async.carry", 32'(carry), 32'd0);
    chk("async.set_sel", 32'(set_sel), 32'd0);
    chk("async.set_bits", 32'(set_bits), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(B_NONE, T235959);
      chk($sformatf("release[%0d].state", k), 32'(state), 32'd0);
      chk($sformatf("release[%0d].r_count", k), 32'(r_count), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
